// File: rtl/axi4_lite_nn_master_pkg.sv
// Shared types and helpers for the NN-slave AXI4-Lite master.
// State encoding, response codes and word-to-byte addressing.
package axi4_lite_nn_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_FINISH
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [3:0] STRB_ALL  = 4'hF;

  function automatic logic [31:0] word_addr(input logic [31:0] w);
    return w << 2;
  endfunction

endpackage

// File: rtl/axi4_lite_nn_master_axi_wait_timer.sv
// Wait counter shared by all channel phases of the master.
// Cleared on phase entry/handshake; flags when the limit is hit.
module axi_wait_timer #(
  parameter int LIMIT = 4096
) (
  input  logic ACLK,
  input  logic rst,
  input  logic clr,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(LIMIT - 1));

  // count idle cycles, hold at the limit until cleared
  always_ff @(posedge ACLK or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axi4_lite_nn_master.sv
// AXI4-Lite master: writes an image into the NN slave and
// reads back the prediction register to trigger inference.
module axi4_lite_nn_master
  import axi4_lite_nn_master_pkg::*;
#(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_WORDS    = 24,
  parameter int RESULT_IDX = 24,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          ACLK,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N_WORDS*DATA_WIDTH-1:0] image,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [3:0]                    prediction,
  output logic [ADDRESS-1:0]            M_AWADDR,
  output logic                          M_AWVALID,
  input  logic                          M_AWREADY,
  output logic [DATA_WIDTH-1:0]         M_WDATA,
  output logic [3:0]                    M_WSTRB,
  output logic                          M_WVALID,
  input  logic                          M_WREADY,
  input  logic [1:0]                    M_BRESP,
  input  logic                          M_BVALID,
  output logic                          M_BREADY,
  output logic [ADDRESS-1:0]            M_ARADDR,
  output logic                          M_ARVALID,
  input  logic                          M_ARREADY,
  input  logic [DATA_WIDTH-1:0]         M_RDATA,
  input  logic [1:0]                    M_RRESP,
  input  logic                          M_RVALID,
  output logic                          M_RREADY
);

  localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_WORDS - 1);

  state_t                        state;
  logic [N_WORDS*DATA_WIDTH-1:0] shadow;
  logic [IW-1:0]                 idx;
  logic [IW-1:0]                 nxt;
  logic aw_done, w_done;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, hs;
  logic tmr_clr, expired, tmo;
  logic unused_rdata;

  assign nxt   = idx + 1'b1;
  assign aw_hs = M_AWVALID & M_AWREADY;
  assign w_hs  = M_WVALID & M_WREADY;
  assign b_hs  = M_BREADY & M_BVALID;
  assign ar_hs = M_ARVALID & M_ARREADY;
  assign r_hs  = M_RREADY & M_RVALID;
  assign hs    = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  assign tmr_clr = hs
                 | (state == S_IDLE)
                 | (state == S_FINISH);
  assign tmo = expired & ~hs;

  assign unused_rdata = ^M_RDATA[DATA_WIDTH-1:4];

  axi_wait_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .ACLK   (ACLK),
    .rst    (rst),
    .clr    (tmr_clr),
    .expired(expired)
  );

  // transaction sequencer with registered channel outputs
  always_ff @(posedge ACLK or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      shadow     <= '0;
      idx        <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      prediction <= '0;
      M_AWADDR   <= '0;
      M_AWVALID  <= 1'b0;
      M_WDATA    <= '0;
      M_WSTRB    <= '0;
      M_WVALID   <= 1'b0;
      M_BREADY   <= 1'b0;
      M_ARADDR   <= '0;
      M_ARVALID  <= 1'b0;
      M_RREADY   <= 1'b0;
    end else if (tmo && state != S_IDLE
                     && state != S_FINISH) begin
      M_AWVALID <= 1'b0;
      M_WVALID  <= 1'b0;
      M_BREADY  <= 1'b0;
      M_ARVALID <= 1'b0;
      M_RREADY  <= 1'b0;
      err       <= 1'b1;
      done      <= 1'b1;
      state     <= S_FINISH;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            shadow    <= image;
            idx       <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            M_AWADDR  <= '0;
            M_WDATA   <= image[DATA_WIDTH-1:0];
            M_WSTRB   <= STRB_ALL;
            M_AWVALID <= 1'b1;
            M_WVALID  <= 1'b1;
            state     <= S_WADDR;
          end
        end
        S_WADDR: begin
          if (aw_hs) begin
            M_AWVALID <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            M_WVALID <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            M_BREADY <= 1'b1;
            state    <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (b_hs) begin
            M_BREADY <= 1'b0;
            if (M_BRESP != RESP_OKAY) err <= 1'b1;
            if (idx == LAST) begin
              M_ARADDR  <= ADDRESS'(word_addr(32'(RESULT_IDX)));
              M_ARVALID <= 1'b1;
              state     <= S_RADDR;
            end else begin
              idx       <= nxt;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              M_AWADDR  <= ADDRESS'(word_addr(32'(nxt)));
              M_WDATA   <= shadow[nxt*DATA_WIDTH +: DATA_WIDTH];
              M_AWVALID <= 1'b1;
              M_WVALID  <= 1'b1;
              state     <= S_WADDR;
            end
          end
        end
        S_RADDR: begin
          if (ar_hs) begin
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b1;
            state     <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (r_hs) begin
            M_RREADY   <= 1'b0;
            prediction <= M_RDATA[3:0];
            if (M_RRESP != RESP_OKAY) err <= 1'b1;
            done       <= 1'b1;
            state      <= S_FINISH;
          end
        end
        S_FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_nn_master.sv
// Self-checking bench for axi4_lite_nn_master.
// Reactive slave model plus a cycle/transaction reference model.
module tb_axi4_lite_nn_master;

  localparam int N  = 24;
  localparam int RI = 24;
  localparam int T  = 64;

  logic          ACLK = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N*32-1:0] image = '0;
  logic          busy, done, err;
  logic [3:0]    prediction;
  logic [31:0]   M_AWADDR, M_WDATA, M_ARADDR;
  logic          M_AWVALID, M_WVALID, M_BREADY;
  logic          M_ARVALID, M_RREADY;
  logic [3:0]    M_WSTRB;
  logic          M_AWREADY = 0, M_WREADY = 0;
  logic          M_BVALID = 0, M_ARREADY = 0, M_RVALID = 0;
  logic [1:0]    M_BRESP = 0, M_RRESP = 0;
  logic [31:0]   M_RDATA = 0;

  axi4_lite_nn_master #(
    .TIMEOUT(T)
  ) dut (
    .ACLK(ACLK), .rst(rst), .start(start), .image(image),
    .busy(busy), .done(done), .err(err),
    .prediction(prediction),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID),
    .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
    .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID),
    .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID),
    .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  initial forever #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // slave behaviour knobs and bookkeeping
  int aw_lat, w_lat, r_lat, bad_word;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  int aw_wait, w_wait, r_wait, b_cnt;
  bit aw_got, w_got, b_pend, r_pend;
  bit aw_drop, w_drop;
  logic [31:0] aw_hold, w_hold;
  logic [31:0] wa_q[$], wd_q[$], ra_q[$];
  logic [3:0]  ws_q[$];
  logic [3:0]  pred_m = 4'h0;

  task automatic slave_clear();
    aw_wait = 0; w_wait = 0; r_wait = 0; b_cnt = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_drop = 0; w_drop = 0;
    wa_q.delete(); wd_q.delete();
    ra_q.delete(); ws_q.delete();
    M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0;
    M_BRESP = 0; M_ARREADY = 0; M_RVALID = 0;
    M_RDATA = 0; M_RRESP = 0;
  endtask

  // reactive slave: decides this cycle's inputs at negedge
  initial begin : slave
    aw_lat = 0; w_lat = 0; r_lat = 0; bad_word = 99;
    r_data = 0; r_resp = 0;
    slave_clear();
    forever begin
      @(negedge ACLK);
      if (rst) begin
        slave_clear();
      end else begin
        if (aw_drop) chk("awvalid_drop", M_AWVALID, 0);
        if (w_drop) chk("wvalid_drop", M_WVALID, 0);
        aw_drop = 0;
        w_drop = 0;
        M_AWREADY = M_AWVALID && aw_wait >= aw_lat;
        M_WREADY  = M_WVALID && w_wait >= w_lat;
        M_BVALID  = b_pend;
        M_BRESP   = (b_pend && b_cnt == bad_word)
                  ? 2'b10 : 2'b00;
        M_ARREADY = M_ARVALID;
        M_RVALID  = r_pend && r_wait >= r_lat;
        M_RDATA   = M_RVALID ? r_data : 32'h0;
        M_RRESP   = M_RVALID ? r_resp : 2'b00;
        if (M_AWVALID) begin
          if (aw_wait > 0) chk("awaddr_hold", M_AWADDR, aw_hold);
          aw_hold = M_AWADDR;
          if (M_AWREADY) begin
            wa_q.push_back(M_AWADDR);
            aw_wait = 0; aw_got = 1; aw_drop = 1;
          end else aw_wait++;
        end
        if (M_WVALID) begin
          if (w_wait > 0) chk("wdata_hold", M_WDATA, w_hold);
          w_hold = M_WDATA;
          if (M_WREADY) begin
            wd_q.push_back(M_WDATA);
            ws_q.push_back(M_WSTRB);
            w_wait = 0; w_got = 1; w_drop = 1;
          end else w_wait++;
        end
        if (M_BVALID && M_BREADY) begin
          b_pend = 0;
          b_cnt++;
        end
        if (aw_got && w_got) begin
          b_pend = 1; aw_got = 0; w_got = 0;
        end
        if (M_ARVALID) begin
          ra_q.push_back(M_ARADDR);
          r_pend = 1;
          r_wait = 0;
        end else if (r_pend) begin
          if (M_RVALID && M_RREADY) r_pend = 0;
          else if (!M_RVALID) r_wait++;
        end
      end
    end
  end

  // one complete image transfer with expectations from the model
  task automatic run(input string nm,
                     input int awl, input int wl,
                     input int rl, input int badw,
                     input logic [31:0] rd,
                     input logic [1:0] rr,
                     input bit fixed_img, input bit hold);
    logic [N*32-1:0] img;
    int cyc, exp_cyc, m;
    bit tmo, seen;
    logic exp_err;
    for (int k = 0; k < N; k++)
      img[k*32 +: 32] = fixed_img ? 32'hA5000000 + k
                                  : $urandom;
    @(negedge ACLK);
    #1;
    aw_lat = awl; w_lat = wl; r_lat = rl;
    bad_word = badw; r_data = rd; r_resp = rr;
    slave_clear();
    m = (awl > wl) ? awl : wl;
    tmo = rl >= T;
    exp_cyc = N * (2 + m) + 3 + (tmo ? T - 1 : rl);
    exp_err = (badw < N) || tmo || (rr != 2'b00);
    if (!tmo) pred_m = rd[3:0];
    image = img;
    start = 1'b1;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 3000) begin
      @(negedge ACLK);
      cyc++;
      if (cyc == 1) begin
        chk({nm, ":valid_c1"},
            {M_AWVALID, M_WVALID, busy}, 3'b111);
        chk({nm, ":err_clr"}, err, 0);
        image = ~img;
        if (!hold) start = 1'b0;
      end
      if (done) seen = 1;
    end
    start = 1'b0;
    chk({nm, ":done_seen"}, seen, 1);
    chk({nm, ":latency"}, cyc, exp_cyc);
    chk({nm, ":prediction"}, prediction, pred_m);
    chk({nm, ":err"}, err, exp_err);
    chk({nm, ":valids_low"},
        {M_AWVALID, M_WVALID, M_ARVALID,
         M_BREADY, M_RREADY}, 0);
    chk({nm, ":n_writes"}, wa_q.size(), N);
    for (int k = 0; k < N && k < wa_q.size(); k++) begin
      chk($sformatf("%s:waddr[%0d]", nm, k), wa_q[k], k * 4);
      chk($sformatf("%s:wdata[%0d]", nm, k),
          wd_q[k], img[k*32 +: 32]);
      chk($sformatf("%s:wstrb[%0d]", nm, k), ws_q[k], 4'hF);
    end
    chk({nm, ":n_reads"}, ra_q.size(), 1);
    if (ra_q.size() > 0)
      chk({nm, ":raddr"}, ra_q[0], RI * 4);
    @(negedge ACLK);
    chk({nm, ":done_pulse"}, {done, busy}, 2'b00);
    chk({nm, ":err_sticky"}, err, exp_err);
  endtask

  initial begin : stim
    repeat (3) @(negedge ACLK);
    chk("rst_valids",
        {M_AWVALID, M_WVALID, M_BREADY,
         M_ARVALID, M_RREADY}, 0);
    chk("rst_status", {busy, done, err, prediction}, 0);
    chk("rst_addr", {M_AWADDR, M_WDATA}, 0);
    rst = 1'b0;
    @(negedge ACLK);

    run("zero_wait", 0, 0, 0, 99, 32'h7, 2'b00, 1, 0);
    run("aw_early", 0, 2, 3, 99, $urandom, 2'b00, 0, 0);
    run("bresp_err", 0, 0, 1, 5, $urandom, 2'b00, 0, 0);
    run("r_timeout", 0, 0, 1000, 99, 32'h5, 2'b00, 0, 0);
    run("rresp_err", 1, 0, 2, 99, $urandom, 2'b10, 0, 0);

    for (int r = 0; r < 3; r++)
      run($sformatf("rand%0d", r),
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 10), $urandom_range(0, 40),
          $urandom, 2'b00, 0, 0);

    // reset in the middle of word 10
    slave_clear();
    aw_lat = 0; w_lat = 0; r_lat = 0; bad_word = 99;
    image = {N{32'hDEADBEEF}};
    @(negedge ACLK);
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    for (int i = 0; i < 200 && wa_q.size() < 10; i++) begin
      @(negedge ACLK);
      #1;
    end
    chk("mid_word10", wa_q.size(), 10);
    rst = 1'b1;
    #1;
    chk("mid_rst_valids",
        {M_AWVALID, M_WVALID, M_BREADY,
         M_ARVALID, M_RREADY}, 0);
    chk("mid_rst_status", {busy, done, err, prediction}, 0);
    chk("mid_rst_addr", {M_AWADDR, M_WDATA, M_ARADDR}, 0);
    pred_m = 4'h0;
    repeat (2) @(negedge ACLK);
    rst = 1'b0;
    run("after_rst", 0, 0, 0, 99, $urandom, 2'b00, 0, 0);

    run("start_held", 0, 0, 4, 99, $urandom, 2'b00, 0, 1);
    repeat (5) @(negedge ACLK);
    chk("held_no_rerun", {M_AWVALID, busy}, 0);
    chk("held_txn_count", wa_q.size() + ra_q.size(), N + 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
